// File: rtl/nx_fifo_rd_pkg.sv
// Shared constants and elaboration helpers for the nx_fifo read-side stream reader.
package nx_fifo_rd_pkg;

    localparam int FIFO_W = 64;

    function automatic bit legal_out_w(input int w);
        return (w == 8) || (w == 16) || (w == 32) || (w == 64);
    endfunction

    function automatic int ratio(input int w);
        return FIFO_W / w;
    endfunction

    // A 1-bit index is kept even when a word is a single beat.
    function automatic int idx_w(input int w);
        return (ratio(w) > 1) ? $clog2(ratio(w)) : 1;
    endfunction

endpackage

// File: rtl/nx_fifo_rd_unpack.sv
// Holds one popped FIFO word and walks it out as OUT_W slices, LSB slice first.
module nx_fifo_rd_unpack
    import nx_fifo_rd_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [FIFO_W-1:0] load_data,
    input  logic              advance,
    input  logic              rel,
    output logic              held,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last
);

    localparam int RATIO = ratio(OUT_W);
    localparam int IDX_W = idx_w(OUT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    logic [FIFO_W-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              held_q, held_d;

    // Load beats release so the next word follows the last beat with no bubble.
    always_comb begin
        buf_d  = buf_q;
        idx_d  = idx_q;
        held_d = held_q;
        if (clear) begin
            held_d = 1'b0;
            idx_d  = '0;
        end else if (load) begin
            buf_d  = load_data;
            idx_d  = '0;
            held_d = 1'b1;
        end else if (rel) begin
            held_d = 1'b0;
            idx_d  = '0;
        end else if (advance) begin
            idx_d  = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            idx_q  <= '0;
            held_q <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            idx_q  <= idx_d;
            held_q <= held_d;
        end
    end

    generate
        if (RATIO == 1) begin : g_full
            assign out_data = buf_q;
        end else begin : g_slice
            assign out_data = buf_q[idx_q*OUT_W +: OUT_W];
        end
    endgenerate

    assign held     = held_q;
    assign out_last = held_q && (idx_q == LAST_IDX);

endmodule

// File: rtl/nx_fifo_stream_reader.sv
// Pops 64-bit words from nx_fifo and streams them downstream as OUT_W beats.
module nx_fifo_stream_reader
    import nx_fifo_rd_pkg::*;
#(
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clear,
    input  logic              fifo_empty,
    input  logic [FIFO_W-1:0] fifo_rdata,
    output logic              fifo_ren,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              busy
);

    generate
        if (!legal_out_w(OUT_W)) begin : g_bad_out_w
            $error("nx_fifo_stream_reader: OUT_W must be 8, 16, 32 or 64");
        end
    endgenerate

    logic             held, last, xfer;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    assign xfer = held && out_ready;

    // rst_n gates the pop so a FIFO is never drained while the reader is in reset.
    assign fifo_ren = rst_n && enable && !clear && !fifo_empty &&
                      (!held || (out_ready && last));

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (fifo_ren) word_cnt_d = word_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) word_cnt_q <= '0;
        else        word_cnt_q <= word_cnt_d;
    end

    nx_fifo_rd_unpack #(.OUT_W(OUT_W)) u_unpack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .load      (fifo_ren),
        .load_data (fifo_rdata),
        .advance   (xfer && !last),
        .rel       (xfer && last),
        .held      (held),
        .out_data  (out_data),
        .out_last  (last)
    );

    assign out_valid = held;
    assign out_last  = last;
    assign busy      = held;
    assign word_cnt  = word_cnt_q;

endmodule
